niosii_system_sysid_checker: RTL

Avalon-MM master that reads the system ID peripheral's two words (ID at word address 0, build timestamp at word address 1) after a start pulse and compares them against expected values. It sits in the Qsys system beside the sysid slave and gives hardware a self-check for the loaded image: a done pulse plus held match/timeout flags. Reads are issued strictly one at a time, with full waitrequest/readdatavalid handshaking and a per-read timeout.

---
 rtl/niosii_system_sysid_checker_if.sv | 24 ++
 rtl/niosii_system_sysid_checker.sv | 124 ++++++++++++
 2 files changed

// File: rtl/niosii_system_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the sysid slave.
interface niosii_system_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/niosii_system_sysid_checker.sv
// Reads sysid ID and build timestamp over Avalon-MM, one read at a time, and
// compares them against the expected image values with a per-read timeout.
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h58DD_6C60,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                start,
    niosii_system_sysid_checker_if.master       bus,
    output logic                                busy,
    output logic                                done,
    output logic                                id_match,
    output logic                                ts_match,
    output logic                                timeout,
    output logic [31:0]                         read_id,
    output logic [31:0]                         read_ts
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_EDGE = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, DONE
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          in_xfer;
    logic          complete;
    logic          expired;
    logic          avm_read_c;
    logic          avm_address_c;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        in_xfer       = 1'b0;
        complete      = 1'b0;
        expired       = 1'b0;
        avm_read_c    = 1'b0;
        avm_address_c = 1'b0;
        case (state)
            IDLE: if (start) state_next = REQ_ID;
            REQ_ID: begin
                in_xfer    = 1'b1;
                avm_read_c = 1'b1;
                if (!bus.avm_waitrequest) state_next = WAIT_ID;
            end
            WAIT_ID: begin
                in_xfer = 1'b1;
                if (bus.avm_readdatavalid) begin
                    complete   = 1'b1;
                    state_next = REQ_TS;
                end
            end
            REQ_TS: begin
                in_xfer       = 1'b1;
                avm_read_c    = 1'b1;
                avm_address_c = 1'b1;
                if (!bus.avm_waitrequest) state_next = WAIT_TS;
            end
            WAIT_TS: begin
                in_xfer       = 1'b1;
                avm_address_c = 1'b1;
                if (bus.avm_readdatavalid) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A response landing on the final allowed edge still counts as on time.
        if (in_xfer && (cnt == LAST_EDGE) && !complete) begin
            expired    = 1'b1;
            state_next = DONE;
        end
    end

    assign bus.avm_read    = avm_read_c;
    assign bus.avm_address = avm_address_c;
    assign busy            = (state != IDLE);
    assign done            = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
            read_id  <= '0;
            read_ts  <= '0;
        end else if (state == IDLE && start) begin
            cnt      <= '0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
            read_id  <= '0;
            read_ts  <= '0;
        end else if (in_xfer) begin
            cnt <= complete ? '0 : cnt + CW'(1);
            if (complete && state == WAIT_ID) read_id <= bus.avm_readdata;
            if (complete && state == WAIT_TS) begin
                read_ts  <= bus.avm_readdata;
                id_match <= (read_id == EXPECTED_ID);
                ts_match <= (bus.avm_readdata == EXPECTED_TIMESTAMP);
            end
            if (expired) begin
                timeout  <= 1'b1;
                id_match <= 1'b0;
                ts_match <= 1'b0;
            end
        end
    end
endmodule
